// File: rtl/crc_sig_pkg.sv
// Shared types and step functions for the crc/signature harness.
// The step functions take a 64-bit form plus the live width; bits above the width are masked off.
package crc_sig_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WARMUP,
    ACCUM,
    CHECK,
    DONE
  } state_e;

  localparam logic [63:0] DEFAULT_SEED = 64'h5aef0c8d_d70a4497;

  // Shift left by one, feeding back x[w-1]^x[2]^x[0] into bit 0.
  function automatic logic [63:0] lfsr_step(input logic [63:0] x, input int w);
    logic [63:0] mask;
    logic [5:0]  msb;
    // w==64 shifts the one out entirely, so the subtraction wraps to all ones.
    mask = (64'd1 << w) - 64'd1;
    msb  = 6'(w - 1);
    return ((x << 1) & mask) | {63'd0, x[msb] ^ x[2] ^ x[0]};
  endfunction

  function automatic logic [63:0] sig_step(input logic [63:0] s, input logic [63:0] r,
                                           input int w);
    return r ^ lfsr_step(s, w);
  endfunction

endpackage

// File: rtl/crc_sig_reg.sv
// WIDTH-bit register that loads, clears, or takes one signature step per enabled cycle.
// With xor_in tied to zero the signature step degenerates to a plain LFSR step.
module crc_sig_reg
  import crc_sig_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] xor_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= WIDTH'(sig_step(64'(q), 64'(xor_in), WIDTH));
    end
  end

endmodule

// File: rtl/crc_sig_harness.sv
// Drives an LFSR stimulus into a block under test, folds its results into a signature,
// and checks both against expected values at a fixed cycle.
module crc_sig_harness
  import crc_sig_pkg::*;
#(
  parameter int          WIDTH      = 64,
  parameter logic [63:0] SEED       = DEFAULT_SEED,
  parameter int          WARMUP_CYC = 10,
  parameter int          FINAL_CYC  = 99,
  parameter logic [63:0] EXP_CRC    = 64'hc77bb9b3_784ea091,
  parameter logic [63:0] EXP_SUM    = 64'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] result_i,
  input  logic             result_vld_i,
  output logic [WIDTH-1:0] crc_o,
  output logic [WIDTH-1:0] sum_o,
  output logic [31:0]      cyc_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output state_e           state_o
);

  localparam logic [WIDTH-1:0] SEED_W     = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] EXP_CRC_W  = EXP_CRC[WIDTH-1:0];
  localparam logic [WIDTH-1:0] EXP_SUM_W  = EXP_SUM[WIDTH-1:0];
  localparam logic [31:0]      WARM_LAST  = 32'(WARMUP_CYC - 1);
  localparam logic [31:0]      FINAL_LAST = 32'(FINAL_CYC - 1);

  state_e state;

  // Handshake: start is a single-cycle request honoured only in IDLE/DONE; result_vld_i
  // qualifies result_i in the same cycle and the harness never applies backpressure.
  logic crc_load, crc_en, sum_load, sum_clr, sum_en;

  assign crc_load = (state == SETUP);
  assign crc_en   = (state == WARMUP) || (state == ACCUM);
  assign sum_load = (state == SETUP);
  assign sum_clr  = (state == WARMUP);
  assign sum_en   = (state == ACCUM) && result_vld_i;

  crc_sig_reg #(.WIDTH(WIDTH)) u_crc (
    .clk      (clk),
    .rst      (rst),
    .load     (crc_load),
    .load_val (SEED_W),
    .clr      (1'b0),
    .en       (crc_en),
    .xor_in   ('0),
    .q        (crc_o)
  );

  crc_sig_reg #(.WIDTH(WIDTH)) u_sum (
    .clk      (clk),
    .rst      (rst),
    .load     (sum_load),
    .load_val ('0),
    .clr      (sum_clr),
    .en       (sum_en),
    .xor_in   (result_i),
    .q        (sum_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cyc_o  <= '0;
      done_o <= 1'b0;
      pass_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SETUP;
            cyc_o <= '0;
          end
        end
        SETUP: begin
          cyc_o <= 32'd1;
          state <= (WARMUP_CYC <= 1) ? ACCUM : WARMUP;
        end
        WARMUP: begin
          cyc_o <= cyc_o + 32'd1;
          if (cyc_o == WARM_LAST) state <= ACCUM;
        end
        ACCUM: begin
          cyc_o <= cyc_o + 32'd1;
          if (cyc_o == FINAL_LAST) state <= CHECK;
        end
        CHECK: begin
          pass_o <= (crc_o == EXP_CRC_W) && (sum_o == EXP_SUM_W);
          done_o <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          if (start) begin
            state  <= SETUP;
            cyc_o  <= '0;
            done_o <= 1'b0;
            pass_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o  = (state == SETUP) || (state == WARMUP) || (state == ACCUM) || (state == CHECK);
  assign state_o = state;

endmodule

// File: tb/tb_crc_sig_harness.sv
// Directed bench for crc_sig_harness: a default 100-cycle run plus two short runs
// with a seed of 1, all checked every cycle against a run-timeline model.
module tb_crc_sig_harness;
  import crc_sig_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [63:0] res0, res_one;
  logic        vld0, vld_one;

  logic [63:0] crc_w [3];
  logic [63:0] sum_w [3];
  logic [31:0] cyc_w [3];
  logic        busy_w[3];
  logic        done_w[3];
  logic        pass_w[3];
  state_e      st_w  [3];

  crc_sig_harness dut (
    .clk(clk), .rst(rst), .start(start), .result_i(res0), .result_vld_i(vld0),
    .crc_o(crc_w[0]), .sum_o(sum_w[0]), .cyc_o(cyc_w[0]), .busy_o(busy_w[0]),
    .done_o(done_w[0]), .pass_o(pass_w[0]), .state_o(st_w[0])
  );

  crc_sig_harness #(
    .SEED(64'h1), .WARMUP_CYC(4), .FINAL_CYC(6), .EXP_CRC(64'h3a), .EXP_SUM(64'h2)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .result_i(res_one), .result_vld_i(vld_one),
    .crc_o(crc_w[1]), .sum_o(sum_w[1]), .cyc_o(cyc_w[1]), .busy_o(busy_w[1]),
    .done_o(done_w[1]), .pass_o(pass_w[1]), .state_o(st_w[1])
  );

  crc_sig_harness #(
    .SEED(64'h1), .WARMUP_CYC(1), .FINAL_CYC(3), .EXP_CRC(64'h7), .EXP_SUM(64'h3)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .result_i(res_one), .result_vld_i(vld_one),
    .crc_o(crc_w[2]), .sum_o(sum_w[2]), .cyc_o(cyc_w[2]), .busy_o(busy_w[2]),
    .done_o(done_w[2]), .pass_o(pass_w[2]), .state_o(st_w[2])
  );

  // ---------------- model ----------------
  logic [63:0] seed_c [3] = '{64'h5aef0c8dd70a4497, 64'h1, 64'h1};
  logic [63:0] ecrc_c [3] = '{64'hc77bb9b3784ea091, 64'h3a, 64'h7};
  logic [63:0] esum_c [3] = '{64'h0, 64'h2, 64'h3};
  int          warm_c [3] = '{10, 4, 1};
  int          fin_c  [3] = '{99, 6, 3};

  // mj = edges since the accepted start (0 = never started since reset)
  int          mj    [3];
  logic [63:0] m_crc [3];
  logic [63:0] m_sum [3];
  bit          m_pass[3];

  function automatic logic [63:0] lstep(input logic [63:0] x);
    return {x[62:0], x[63] ^ x[2] ^ x[0]};
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      mj[i] = 0; m_crc[i] = '0; m_sum[i] = '0; m_pass[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [63:0] r;
      logic        v;
      int          c;
      r = (i == 0) ? res0 : res_one;
      v = (i == 0) ? vld0 : vld_one;
      if (rst) begin
        mj[i] = 0; m_crc[i] = '0; m_sum[i] = '0; m_pass[i] = 1'b0;
      end else if (start && (mj[i] == 0 || mj[i] >= fin_c[i] + 2)) begin
        mj[i] = 1; m_pass[i] = 1'b0;
      end else if (mj[i] >= 1 && mj[i] <= fin_c[i] + 1) begin
        c = mj[i] - 1;
        if (mj[i] == 1) begin
          m_crc[i] = seed_c[i]; m_sum[i] = '0;
        end else if (c < fin_c[i]) begin
          m_crc[i] = lstep(m_crc[i]);
          if (c >= warm_c[i] && v) m_sum[i] = r ^ lstep(m_sum[i]);
        end else begin
          m_pass[i] = (m_crc[i] == ecrc_c[i]) && (m_sum[i] == esum_c[i]);
        end
        mj[i] = mj[i] + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        logic [31:0] e_cyc;
        bit e_busy, e_done, e_pass;
        e_cyc  = (mj[i] == 0) ? 32'd0 :
                 (mj[i] - 1 < fin_c[i]) ? 32'(mj[i] - 1) : 32'(fin_c[i]);
        e_busy = (mj[i] >= 1) && (mj[i] <= fin_c[i] + 1);
        e_done = (mj[i] >= fin_c[i] + 2);
        e_pass = m_pass[i];
        n_vec++;
        if (crc_w[i] !== m_crc[i] || sum_w[i] !== m_sum[i] || cyc_w[i] !== e_cyc ||
            busy_w[i] !== e_busy || done_w[i] !== e_done || pass_w[i] !== e_pass) begin
          n_err++;
          $display("FAIL model[%0d] t=%0t crc=%h/%h sum=%h/%h cyc=%0d/%0d busy=%b/%b done=%b/%b pass=%b/%b",
                   i, $time, crc_w[i], m_crc[i], sum_w[i], m_sum[i], cyc_w[i], e_cyc,
                   busy_w[i], e_busy, done_w[i], e_done, pass_w[i], e_pass);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_case(input bit toggle, input int abort_at, input int xs0, input int xs1);
    int done_k;
    bit saw;
    done_k = 0;
    res0   = toggle ? 64'h1 : 64'h0;
    vld0   = 1'b1;
    start  = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (toggle) vld0 = ~vld0;
      if (k == xs0 || k == xs1) start = 1'b1;
      if (done_w[0] && done_k == 0) done_k = k;
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_crc", crc_w[0], 64'h0);
        chk("abort_sum", sum_w[0], 64'h0);
        chk("abort_cyc", 64'(cyc_w[0]), 64'h0);
        chk("abort_busy", 64'(busy_w[0]), 64'h0);
        saw = 1'b0;
        repeat (120) begin
          @(negedge clk);
          if (done_w[0]) saw = 1'b1;
        end
        chk("abort_no_done", 64'(saw), 64'h0);
        return;
      end
      case (k)
        1: begin
          chk("setup_busy", 64'(busy_w[0]), 64'h1);
          chk("setup_cyc", 64'(cyc_w[0]), 64'h0);
          chk("setup_done_clr", 64'(done_w[0]), 64'h0);
          chk("setup_pass_clr", 64'(pass_w[0]), 64'h0);
        end
        2: chk("crc_seed", crc_w[0], 64'h5aef0c8dd70a4497);
        3: chk("crc_step1", crc_w[0], 64'hb5de191bae14892e);
        4: chk("b_check_crc", crc_w[2], 64'h7);
        5: begin
          chk("a_sum_c4", sum_w[1], 64'h0);
          chk("b_done", 64'(done_w[2]), 64'h1);
          chk("b_pass", 64'(pass_w[2]), 64'h0);
          chk("b_sum", sum_w[2], 64'h2);
        end
        6: chk("a_sum_c5", sum_w[1], 64'h1);
        7: begin
          chk("a_sum_c6", sum_w[1], 64'h2);
          chk("a_check_crc", crc_w[1], 64'h3a);
        end
        8: begin
          chk("a_done", 64'(done_w[1]), 64'h1);
          chk("a_pass", 64'(pass_w[1]), 64'h1);
        end
        100: begin
          chk("check_crc", crc_w[0], 64'hc77bb9b3784ea091);
          chk("check_done_low", 64'(done_w[0]), 64'h0);
          if (!toggle) chk("check_sum", sum_w[0], 64'h0);
        end
        default: ;
      endcase
    end
    chk("done_latency", 64'(done_k), 64'd101);
    if (!toggle) chk("main_pass", 64'(pass_w[0]), 64'h1);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b1;
    res0    = '0;
    vld0    = 1'b0;
    res_one = 64'h1;
    vld_one = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_crc", crc_w[0], 64'h0);
    chk("rst_sum", sum_w[0], 64'h0);
    chk("rst_cyc", 64'(cyc_w[0]), 64'h0);
    chk("rst_busy", 64'(busy_w[0]), 64'h0);
    chk("rst_done", 64'(done_w[0]), 64'h0);
    chk("rst_pass", 64'(pass_w[0]), 64'h0);
    chk("rst_state", 64'(st_w[0]), 64'(IDLE));
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);

    run_case(1'b0, 0, 0, 0);   // zero results, expect pass
    run_case(1'b1, 0, 0, 0);   // toggling valid, restarted from DONE
    run_case(1'b0, 51, 0, 0);  // reset mid-ACCUM at cyc 50
    run_case(1'b0, 0, 0, 0);   // clean run after abort
    run_case(1'b0, 0, 5, 40);  // start pulses during WARMUP and ACCUM
    run_case(1'b0, 0, 0, 0);   // restart from DONE

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
